// File: rtl/imm_pkg.sv
// ----------------------------------------------------------------------------
// imm_pkg: shared types and constants for the ID-stage immediate controller.
//   - imm_mode_e : extension mode carried with every result (NONE/SIGN/ZERO/LUI)
//   - state_e    : occupancy of the two-entry output/skid buffer
//   - OP_*       : primary opcode constants (instr[31:26])
//   - entry_t    : one buffered result; grows a branch-target field when
//                  IMM_BRANCH_TARGET_EN is defined
//   - op2mode()  : opcode -> extension mode
// ----------------------------------------------------------------------------
package imm_pkg;

  localparam int DATA_W = 32;  // instruction / immediate width (32 only)
  localparam int DEPTH  = 2;   // output reg + skid reg

  typedef enum logic [1:0] {
    IMM_NONE = 2'b00,
    IMM_SIGN = 2'b01,
    IMM_ZERO = 2'b10,
    IMM_LUI  = 2'b11
  } imm_mode_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef struct packed {
    logic [DATA_W-1:0] imm;
    imm_mode_e         mode;
`ifdef IMM_BRANCH_TARGET_EN
    logic [DATA_W-1:0] br_tgt;
`endif
  } entry_t;

  function automatic imm_mode_e op2mode(input logic [5:0] op);
    case (op)
      OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW:
        return IMM_SIGN;
      OP_ANDI, OP_ORI, OP_XORI:
        return IMM_ZERO;
      OP_LUI:
        return IMM_LUI;
      default:
        return IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/imm_ext_ctrl_if.sv
// ----------------------------------------------------------------------------
// imm_ext_ctrl_if: IF/ID -> controller -> ID/EX handshake bundle.
//   in_valid/in_ready/ifid_out : instruction side (valid/ready)
//   out_valid/out_ready        : result side (valid/ready)
//   imm_out/mode_out/imm_used  : result payload
//   pc_plus4/br_target_out     : only with IMM_BRANCH_TARGET_EN
// modport master = producer/consumer environment, slave = the controller.
// ----------------------------------------------------------------------------
interface imm_ext_ctrl_if;
  import imm_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] ifid_out;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] imm_out;
  logic [1:0]        mode_out;
  logic              imm_used;
`ifdef IMM_BRANCH_TARGET_EN
  logic [DATA_W-1:0] pc_plus4;
  logic [DATA_W-1:0] br_target_out;

  modport master (output in_valid, ifid_out, out_ready, pc_plus4,
                  input  in_ready, out_valid, imm_out, mode_out, imm_used, br_target_out);
  modport slave  (input  in_valid, ifid_out, out_ready, pc_plus4,
                  output in_ready, out_valid, imm_out, mode_out, imm_used, br_target_out);
`else
  modport master (output in_valid, ifid_out, out_ready,
                  input  in_ready, out_valid, imm_out, mode_out, imm_used);
  modport slave  (input  in_valid, ifid_out, out_ready,
                  output in_ready, out_valid, imm_out, mode_out, imm_used);
`endif
endinterface

// File: rtl/imm_decode.sv
// ----------------------------------------------------------------------------
// imm_decode: combinational opcode decode and immediate formation.
//   i_instr    in  32  instruction word
//   i_pc_plus4 in  32  PC+4 of the instruction (IMM_BRANCH_TARGET_EN only)
//   o_entry    out     {imm, mode[, br_tgt]} ready to be buffered
// ----------------------------------------------------------------------------
module imm_decode
  import imm_pkg::*;
(
  input  logic [DATA_W-1:0] i_instr,
`ifdef IMM_BRANCH_TARGET_EN
  input  logic [DATA_W-1:0] i_pc_plus4,
`endif
  output entry_t            o_entry
);

  logic [DATA_W-1:0] w_sext;
  imm_mode_e         w_mode;
  logic              w_unused;

  // rs/rt fields carry no immediate information
  assign w_unused = ^i_instr[25:16];
  assign w_mode   = op2mode(i_instr[31:26]);
  assign w_sext   = {{16{i_instr[15]}}, i_instr[15:0]};

  always_comb begin
    o_entry      = '0;
    o_entry.mode = w_mode;
    case (w_mode)
      IMM_SIGN: o_entry.imm = w_sext;
      IMM_ZERO: o_entry.imm = {16'h0, i_instr[15:0]};
      IMM_LUI:  o_entry.imm = {i_instr[15:0], 16'h0};
      default:  o_entry.imm = '0;
    endcase
`ifdef IMM_BRANCH_TARGET_EN
    // target is formed on entry so only one adder exists, ahead of the buffer
    if (i_instr[31:26] == OP_BEQ || i_instr[31:26] == OP_BNE)
      o_entry.br_tgt = i_pc_plus4 + {w_sext[DATA_W-3:0], 2'b00};
`endif
  end

endmodule

// File: rtl/imm_ext_ctrl.sv
// ----------------------------------------------------------------------------
// imm_ext_ctrl: ID-stage immediate controller with a 2-entry skid buffer.
//   clk    in  rising-edge clock
//   rst_n  in  synchronous reset, active low
//   flush  in  drop every buffered entry and any same-cycle input
//   bus    imm_ext_ctrl_if.slave (valid/ready in, valid/ready out, payload)
// Optional: IMM_BRANCH_TARGET_EN adds pc_plus4 / br_target_out on the bus.
// Result appears one cycle after acceptance; in_ready is a register, so it
// never depends combinationally on out_ready.
// ----------------------------------------------------------------------------
module imm_ext_ctrl
  import imm_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  imm_ext_ctrl_if.slave  bus
);

  state_e r_state, w_state_nxt;
  entry_t r_out, r_skid, w_dec;
  logic   r_in_ready;
  logic   w_in_xfer, w_out_xfer;
  logic   w_ld_out_dec, w_ld_out_skid, w_ld_skid;

  imm_decode u_dec (
    .i_instr    (bus.ifid_out),
`ifdef IMM_BRANCH_TARGET_EN
    .i_pc_plus4 (bus.pc_plus4),
`endif
    .o_entry    (w_dec)
  );

  assign w_in_xfer  = bus.in_valid  & r_in_ready;
  assign w_out_xfer = bus.out_ready & (r_state != ST_EMPTY);

  always_comb begin
    w_state_nxt   = r_state;
    w_ld_out_dec  = 1'b0;
    w_ld_out_skid = 1'b0;
    w_ld_skid     = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_in_xfer) begin
          w_state_nxt  = ST_ONE;
          w_ld_out_dec = 1'b1;
        end
        ST_ONE: case ({w_in_xfer, w_out_xfer})
          2'b11: w_ld_out_dec = 1'b1;
          2'b10: begin
            w_ld_skid   = 1'b1;
            w_state_nxt = ST_TWO;
          end
          2'b01: w_state_nxt = ST_EMPTY;
          default: ;
        endcase
        // skid always drains behind the output entry, preserving order
        ST_TWO: if (w_out_xfer) begin
          w_ld_out_skid = 1'b1;
          w_state_nxt   = ST_ONE;
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_TWO);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out  <= '0;
      r_skid <= '0;
    end else begin
      if (w_ld_out_dec)       r_out <= w_dec;
      else if (w_ld_out_skid) r_out <= r_skid;
      if (w_ld_skid)          r_skid <= w_dec;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = (r_state != ST_EMPTY);
  assign bus.imm_out   = r_out.imm;
  assign bus.mode_out  = r_out.mode;
  assign bus.imm_used  = (r_out.mode != IMM_NONE);
`ifdef IMM_BRANCH_TARGET_EN
  assign bus.br_target_out = r_out.br_tgt;
`endif

endmodule

// File: tb/tb_imm_ext_ctrl.sv
// ----------------------------------------------------------------------------
// tb_imm_ext_ctrl: directed scenarios plus randomized traffic, with a queue
// model of the buffer and an arithmetic decode of the immediate rules.
// Inputs change on the falling edge; outputs are compared there too.
// ----------------------------------------------------------------------------
module tb_imm_ext_ctrl;

  typedef struct {
    logic [31:0] imm;
    logic [1:0]  mode;
    logic [31:0] tgt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t q[$];

  imm_ext_ctrl_if bus();

  imm_ext_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    int   op = int'(ins[31:26]);
    int   s  = int'($signed(ins[15:0]));
    e.tgt = 32'h0;
    if (op inside {4, 5, 8, 9, 10, 11, 32, 33, 35, 36, 37, 40, 41, 43}) begin
      e.mode = 2'b01; e.imm = s;
    end else if (op inside {12, 13, 14}) begin
      e.mode = 2'b10; e.imm = {16'h0, ins[15:0]};
    end else if (op == 15) begin
      e.mode = 2'b11; e.imm = {16'h0, ins[15:0]} * 32'd65536;
    end else begin
      e.mode = 2'b00; e.imm = 32'h0;
    end
    if (op == 4 || op == 5) e.tgt = pc + s * 4;
    return e;
  endfunction

  // compare outputs against the model, apply one cycle of stimulus, advance model
  task automatic step(input logic iv, input logic [31:0] ins, input logic ordy,
                      input logic fl, input logic [31:0] pc);
    bit rdy, vld;
    rdy = (q.size() < 2);
    vld = (q.size() > 0);
    chk("in_ready", bus.in_ready, rdy);
    chk("out_valid", bus.out_valid, vld);
    if (vld) begin
      chk("imm_out", bus.imm_out, q[0].imm);
      chk("mode_out", bus.mode_out, q[0].mode);
      chk("imm_used", bus.imm_used, q[0].mode != 2'b00);
`ifdef IMM_BRANCH_TARGET_EN
      chk("br_target", bus.br_target_out, q[0].tgt);
`endif
    end
    bus.in_valid  = iv;
    bus.ifid_out  = ins;
    bus.out_ready = ordy;
    flush         = fl;
`ifdef IMM_BRANCH_TARGET_EN
    bus.pc_plus4  = pc;
`endif
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (vld && ordy) void'(q.pop_front());
      if (iv && rdy) q.push_back(ref_dec(ins, pc));
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.ifid_out = 32'h3C08ABCD;
    bus.out_ready = 1'b0;
    flush = 1'b0;
    repeat (n) begin
      @(posedge clk); @(negedge clk);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_imm", bus.imm_out, 0);
      chk("rst_mode", bus.mode_out, 0);
      chk("rst_used", bus.imm_used, 0);
    end
    q.delete();
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("post_rst_in_ready", bus.in_ready, 1);
  endtask

  logic [5:0] ops [18] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                           6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h23, 6'h2B,
                           6'h11, 6'h3F};

  function automatic logic [31:0] rnd_ins();
    logic [31:0] w = $urandom;
    if ($urandom_range(0, 3) != 0) w[31:26] = ops[$urandom_range(0, 17)];
    return w;
  endfunction

  task automatic rnd_run(input int n);
    for (int i = 0; i < n; i++)
      step($urandom_range(0, 1), rnd_ins(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 19) == 0, $urandom);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.ifid_out = 32'h0;
    bus.out_ready = 1'b0;
`ifdef IMM_BRANCH_TARGET_EN
    bus.pc_plus4 = 32'h0;
`endif
    @(negedge clk);
    do_reset(2);

    // decode sequence, one result per cycle
    step(1, 32'h2008FFFC, 1, 0, 0);
    chk("addi_imm", bus.imm_out, 32'hFFFFFFFC); chk("addi_mode", bus.mode_out, 2'b01);
    step(1, 32'h3508FFFC, 1, 0, 0);
    chk("ori_imm", bus.imm_out, 32'h0000FFFC); chk("ori_mode", bus.mode_out, 2'b10);
    step(1, 32'h3C081234, 1, 0, 0);
    chk("lui_imm", bus.imm_out, 32'h12340000); chk("lui_mode", bus.mode_out, 2'b11);
    step(0, 0, 1, 0, 0);

    // back-pressure fills both entries, then drains in order
    step(1, 32'h2008FFFC, 0, 0, 0);
    step(1, 32'h3508FFFC, 0, 0, 0);
    chk("bp_in_ready", bus.in_ready, 0);
    step(1, 32'h3C081234, 0, 0, 0);
    chk("bp_hold_imm", bus.imm_out, 32'hFFFFFFFC);
    step(0, 0, 1, 0, 0);
    chk("bp_second_imm", bus.imm_out, 32'h0000FFFC);
    chk("bp_ready_after_pop", bus.in_ready, 1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);

    // flush from TWO with a new word offered
    step(1, 32'h2008FFFC, 0, 0, 0);
    step(1, 32'h3508FFFC, 0, 0, 0);
    step(1, 32'h3C081234, 1, 1, 0);
    chk("flush_two_valid", bus.out_valid, 0);
    step(0, 0, 1, 0, 0);
    chk("flush_two_drop", bus.out_valid, 0);
    // flush from ONE while the word could otherwise be accepted
    step(1, 32'h2008FFFC, 0, 0, 0);
    step(1, 32'h3C085555, 1, 1, 0);
    chk("flush_one_valid", bus.out_valid, 0);
    step(0, 0, 1, 0, 0);

    // R-type
    step(1, 32'h01095020, 1, 0, 0);
    chk("rtype_mode", bus.mode_out, 0);
    chk("rtype_used", bus.imm_used, 0);
    chk("rtype_imm", bus.imm_out, 0);
    step(0, 0, 1, 0, 0);

`ifdef IMM_BRANCH_TARGET_EN
    step(1, 32'h1000FFFF, 1, 0, 32'h00400010);
    chk("beq_target", bus.br_target_out, 32'h0040000C);
    step(0, 0, 1, 0, 0);
`endif

    rnd_run(400);
    // fill so reset lands with live entries and nonzero outputs
    step(1, 32'h3C08BEEF, 0, 0, 0);
    step(1, 32'h2008FFFC, 0, 0, 0);
    do_reset(1);
    rnd_run(400);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
